ack_responder: RTL and testbench

ACK_RESPONDER -- requirements
Module: ack_responder

---
 rtl/ack_responder_if.sv | 28 ++
 rtl/ack_responder.sv | 80 ++++++++
 tb/tb_ack_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ack_responder_if.sv
// rtl/ack_responder_if.sv - rx header / tx ack handshake bundle for ack_responder
interface ack_responder_if #(
  parameter int NODE_ID_WIDTH = 8,
  parameter int SEQ_WIDTH     = 8
);
  logic                     rx_valid;
  logic                     rx_ready;
  logic [NODE_ID_WIDTH-1:0] rx_src;
  logic [NODE_ID_WIDTH-1:0] rx_dst;
  logic [SEQ_WIDTH-1:0]     rx_seq;
  logic                     rx_ack_req;
  logic                     rx_is_ack;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [NODE_ID_WIDTH-1:0] tx_src;
  logic [NODE_ID_WIDTH-1:0] tx_dst;
  logic [SEQ_WIDTH-1:0]     tx_seq;

  modport master (
    output rx_valid, rx_src, rx_dst, rx_seq, rx_ack_req, rx_is_ack, tx_ready,
    input  rx_ready, tx_valid, tx_src, tx_dst, tx_seq
  );

  modport slave (
    input  rx_valid, rx_src, rx_dst, rx_seq, rx_ack_req, rx_is_ack, tx_ready,
    output rx_ready, tx_valid, tx_src, tx_dst, tx_seq
  );
endinterface

// File: rtl/ack_responder.sv
// rtl/ack_responder.sv - queues acks for unicast ack-requesting headers addressed to this node
module ack_responder #(
  parameter int NODE_ID_WIDTH = 8,
  parameter int SEQ_WIDTH     = 8,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NODE_ID_WIDTH-1:0] node_id,
  ack_responder_if.slave           bus,
  output logic [15:0]              ack_count,
  output logic [7:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [NODE_ID_WIDTH-1:0] r_nid_mem [DEPTH];
  logic [NODE_ID_WIDTH-1:0] r_src_mem [DEPTH];
  logic [SEQ_WIDTH-1:0]     r_seq_mem [DEPTH];
  logic [AW-1:0]            r_wptr;
  logic [AW-1:0]            r_rptr;
  logic [AW:0]              r_count;
  logic [15:0]              r_ack_count;
  logic [7:0]               r_drop_count;

  logic          w_qualify;
  logic          w_pop;
  logic          w_full;
  logic          w_dup;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_last_idx;

  assign w_qualify = bus.rx_valid && bus.rx_ack_req && !bus.rx_is_ack
                     && (bus.rx_dst == node_id) && (bus.rx_dst != '1);
  assign w_pop      = bus.tx_valid && bus.tx_ready;
  assign w_full     = (r_count == C_FULL);
  assign w_last_idx = r_wptr - 1'b1;

  // The newest entry is the one at wptr-1; once it is popped as the sole entry it no longer suppresses.
  assign w_dup = (r_count != '0) && !(w_pop && r_count == (AW+1)'(1))
                 && (r_src_mem[w_last_idx] == bus.rx_src)
                 && (r_seq_mem[w_last_idx] == bus.rx_seq);

  assign w_push = w_qualify && !w_dup && (!w_full || w_pop);
  assign w_drop = w_qualify && !w_dup && w_full && !w_pop;

  assign bus.rx_ready = 1'b1;
  assign bus.tx_valid = (r_count != '0);
  assign bus.tx_src   = r_nid_mem[r_rptr];
  assign bus.tx_dst   = r_src_mem[r_rptr];
  assign bus.tx_seq   = r_seq_mem[r_rptr];
  assign ack_count    = r_ack_count;
  assign drop_count   = r_drop_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_nid_mem[r_wptr] <= node_id;
      r_src_mem[r_wptr] <= bus.rx_src;
      r_seq_mem[r_wptr] <= bus.rx_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ack_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_pop && r_ack_count != 16'hFFFF) r_ack_count  <= r_ack_count + 16'd1;
      if (w_drop && r_drop_count != 8'hFF)  r_drop_count <= r_drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_ack_responder.sv
// tb/tb_ack_responder.sv - table-driven self-checking bench for ack_responder
module tb_ack_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  node_id = 8'h05;
  logic [15:0] ack_count;
  logic [7:0]  drop_count;
  int          n_total = 0;
  int          n_pass = 0;

  ack_responder_if #(.NODE_ID_WIDTH(8), .SEQ_WIDTH(8)) bus ();

  ack_responder #(.NODE_ID_WIDTH(8), .SEQ_WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .node_id    (node_id),
    .bus        (bus),
    .ack_count  (ack_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  src, dst, seq;
    logic        req, isack, rdy;
    logic        ev;
    logic [7:0]  edst, eseq;
    logic [15:0] eack;
    logic [7:0]  edrop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] src, dst, seq, input logic req, isack, rdy,
                     input logic ev, input logic [7:0] edst, eseq, input logic [15:0] eack,
                     input logic [7:0] edrop);
    vec_t t;
    t.v = v; t.src = src; t.dst = dst; t.seq = seq; t.req = req; t.isack = isack; t.rdy = rdy;
    t.ev = ev; t.edst = edst; t.eseq = eseq; t.eack = eack; t.edrop = edrop;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] src, dst, seq, input logic req, isack, rdy);
    bus.rx_valid = v; bus.rx_src = src; bus.rx_dst = dst; bus.rx_seq = seq;
    bus.rx_ack_req = req; bus.rx_is_ack = isack; bus.tx_ready = rdy;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [7:0] edst, eseq,
                               input logic [15:0] eack, input logic [7:0] edrop);
    check({tag, " tx_valid"}, 32'(bus.tx_valid), 32'(ev));
    if (ev) begin
      check({tag, " tx_src"}, 32'(bus.tx_src), 32'h05);
      check({tag, " tx_dst"}, 32'(bus.tx_dst), 32'(edst));
      check({tag, " tx_seq"}, 32'(bus.tx_seq), 32'(eseq));
    end
    check({tag, " ack_count"}, 32'(ack_count), 32'(eack));
    check({tag, " drop_count"}, 32'(drop_count), 32'(edrop));
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Unqualified headers, then one acked header
    add(1, 8'h02, 8'hFF, 8'h01, 1, 0, 1,  0, 8'h00, 8'h00, 16'd0, 8'd0);
    add(1, 8'h02, 8'h07, 8'h02, 1, 0, 1,  0, 8'h00, 8'h00, 16'd0, 8'd0);
    add(1, 8'h02, 8'h05, 8'h03, 0, 0, 1,  0, 8'h00, 8'h00, 16'd0, 8'd0);
    add(1, 8'h02, 8'h05, 8'h04, 1, 1, 1,  0, 8'h00, 8'h00, 16'd0, 8'd0);
    add(1, 8'h02, 8'h05, 8'h10, 1, 0, 1,  1, 8'h02, 8'h10, 16'd0, 8'd0);
    add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1,  0, 8'h00, 8'h00, 16'd1, 8'd0);
    // Overflow with tx stalled: head holds seq 1, seqs 5 and 6 dropped
    for (int i = 1; i <= 6; i++)
      add(1, 8'h03, 8'h05, 8'(i), 1, 0, 0,  1, 8'h03, 8'h01, 16'd1, (i > 4) ? 8'(i - 4) : 8'd0);
    for (int i = 2; i <= 4; i++)
      add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1,  1, 8'h03, 8'(i), 16'(i), 8'd2);
    add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1,  0, 8'h00, 8'h00, 16'd5, 8'd2);
    // Back-to-back duplicate yields a single entry
    add(1, 8'h02, 8'h05, 8'h20, 1, 0, 0,  1, 8'h02, 8'h20, 16'd5, 8'd2);
    add(1, 8'h02, 8'h05, 8'h20, 1, 0, 0,  1, 8'h02, 8'h20, 16'd5, 8'd2);
    add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1,  0, 8'h00, 8'h00, 16'd6, 8'd2);
    // Fill, push-while-full with pop, then continuous traffic across pointer wraps
    for (int i = 0; i < 4; i++)
      add(1, 8'h0A, 8'h05, 8'(8'h40 + i), 1, 0, 0,  1, 8'h0A, 8'h40, 16'd6, 8'd2);
    add(1, 8'h0A, 8'h05, 8'h44, 1, 0, 1,  1, 8'h0A, 8'h41, 16'd7, 8'd2);
    for (int i = 0; i < 10; i++)
      add(1, 8'h0A, 8'h05, 8'(8'h50 + i), 1, 0, 1,  1, 8'h0A,
          (i < 3) ? 8'(8'h42 + i) : 8'(8'h50 + i - 3), 16'(8 + i), 8'd2);
    for (int i = 0; i < 3; i++)
      add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1,  1, 8'h0A, 8'(8'h57 + i), 16'(18 + i), 8'd2);
    add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1,  0, 8'h00, 8'h00, 16'd21, 8'd2);

    // Reset state: cleared both during and after reset
    repeat (2) @(negedge clk);
    check_outputs("reset_held", 1'b0, 8'h00, 8'h00, 16'd0, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset_released", 1'b0, 8'h00, 8'h00, 16'd0, 8'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].src, vecs[i].dst, vecs[i].seq, vecs[i].req, vecs[i].isack, vecs[i].rdy);
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].edst, vecs[i].eseq,
                    vecs[i].eack, vecs[i].edrop);
    end

    // drop_count saturates at 0xFF
    for (int i = 0; i < 270; i++) begin
      drive(1'b1, 8'h0B, 8'h05, 8'(i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    check_outputs("drop_saturate", 1'b1, 8'h0B, 8'h00, 16'd21, 8'hFF);

    // Asynchronous reset mid-operation discards the queue
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_reset", 1'b0, 8'h00, 8'h00, 16'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h0C, 8'h05, 8'h33, 1'b1, 1'b0, 1'b0);
    #1 check("no_comb_path tx_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    check_outputs("post_reset_push", 1'b1, 8'h0C, 8'h33, 16'd0, 8'd0);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_outputs("post_reset_pop", 1'b0, 8'h00, 8'h00, 16'd1, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
